// File: rtl/i2c_avalon_fifo_if.sv
// Avalon-MM slave bus bundle for the I2C FIFO front-end.
interface i2c_avalon_fifo_if;
    logic        i2c_chipselect;
    logic        i2c_write;
    logic        i2c_read;
    logic [2:0]  i2c_address;
    logic [31:0] i2c_writedata;
    logic [31:0] i2c_readdata;

    modport master (
        output i2c_chipselect, i2c_write, i2c_read, i2c_address, i2c_writedata,
        input  i2c_readdata
    );

    modport slave (
        input  i2c_chipselect, i2c_write, i2c_read, i2c_address, i2c_writedata,
        output i2c_readdata
    );
endinterface

// File: rtl/i2c_avalon_fifo.sv
// Avalon-MM front-end for the I2C byte engine: command FIFO with autonomous dispatch,
// optional RX capture FIFO, and maskable level/edge event interrupts.
module i2c_avalon_fifo #(
    parameter int unsigned CMD_DEPTH = 8,
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned N_EVT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    i2c_avalon_fifo_if.slave  bus,
    output logic              i2c_irq,
    input  logic [N_EVT-1:0]  i2c_evt_n,
    output logic              i2c_reset,
    output logic              core_en,
    output logic [31:0]       core_data,
    output logic [1:0]        core_ben,
    output logic [15:0]       core_dvsr,
    input  logic              core_idle,
    input  logic [31:0]       core_rdata
);
    localparam int unsigned CmdAw = $clog2(CMD_DEPTH);
    localparam int unsigned RxAw  = $clog2(RX_DEPTH);
    localparam logic [CmdAw:0] CmdFullLvl = CMD_DEPTH[CmdAw:0];
    localparam logic [RxAw:0]  RxFullLvl  = RX_DEPTH[RxAw:0];

    typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitDone, StDone} state_e;

    state_e state_q, state_d;

    logic [25:0]      cmd_mem_q [CMD_DEPTH];
    logic [CmdAw-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [CmdAw:0]   cmd_lvl_q, cmd_lvl_d;
    logic [31:0]      rx_mem_q [RX_DEPTH];
    logic [RxAw-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RxAw:0]    rx_lvl_q, rx_lvl_d;

    logic ctrl_rst_q, irq_en_q, rx_en_q, done_ie_q;
    logic cmd_ovf_q, cmd_ovf_d, rx_ovf_q, rx_ovf_d, done_q, done_d;
    logic [15:0]      dvsr_q;
    logic [N_EVT-1:0] evt_pend_q, evt_pend_d, evt_mask_q, evt_mode_q;
    logic [N_EVT-1:0] sync1_q, sync2_q, prev_q, evt_set;
    logic [31:0]      readdata_q, readdata_d;

    logic wr, rd, wr_cmd, wr_ctrl, wr_status, wr_dvsr, wr_pend, wr_mask, wr_mode, flush;
    logic cmd_full, cmd_empty, cmd_pop, cmd_push, rx_full, rx_empty, rx_pop, rx_push_req, rx_push;
    logic [25:0] cmd_head;
    logic [31:0] status_word;
    logic        unused_wdata;

    assign wr        = bus.i2c_chipselect & bus.i2c_write;
    assign rd        = bus.i2c_chipselect & bus.i2c_read;
    assign wr_cmd    = wr && (bus.i2c_address == 3'd0);
    assign wr_ctrl   = wr && (bus.i2c_address == 3'd1);
    assign wr_status = wr && (bus.i2c_address == 3'd2);
    assign wr_dvsr   = wr && (bus.i2c_address == 3'd3);
    assign wr_pend   = wr && (bus.i2c_address == 3'd4);
    assign wr_mask   = wr && (bus.i2c_address == 3'd5);
    assign wr_mode   = wr && (bus.i2c_address == 3'd6);
    assign flush     = wr_ctrl & bus.i2c_writedata[2];
    assign unused_wdata = ^bus.i2c_writedata[31:26];

    assign cmd_full  = (cmd_lvl_q == CmdFullLvl);
    assign cmd_empty = (cmd_lvl_q == '0);
    assign rx_full   = (rx_lvl_q == RxFullLvl);
    assign rx_empty  = (rx_lvl_q == '0);
    assign cmd_head  = cmd_mem_q[cmd_rptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign cmd_pop     = (state_q == StIssue) && !cmd_empty && !flush;
    assign cmd_push    = wr_cmd && (!cmd_full || cmd_pop) && !flush;
    assign rx_pop      = rd && (bus.i2c_address == 3'd0) && !rx_empty && !flush;
    assign rx_push_req = (state_q == StDone) && rx_en_q;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop) && !flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (!cmd_empty && core_idle && !flush) state_d = StIssue;
            StIssue:     state_d = StWaitStart;
            StWaitStart: if (!core_idle) state_d = StWaitDone;
            StWaitDone:  if (core_idle) state_d = StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_wptr_d = cmd_wptr_q;
        cmd_rptr_d = cmd_rptr_q;
        cmd_lvl_d  = cmd_lvl_q;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_lvl_d   = rx_lvl_q;
        if (flush) begin
            cmd_wptr_d = '0;
            cmd_rptr_d = '0;
            cmd_lvl_d  = '0;
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_lvl_d   = '0;
        end else begin
            if (cmd_push) cmd_wptr_d = cmd_wptr_q + 1'b1;
            if (cmd_pop)  cmd_rptr_d = cmd_rptr_q + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_lvl_d = cmd_lvl_q + 1'b1;
                2'b01:   cmd_lvl_d = cmd_lvl_q - 1'b1;
                default: cmd_lvl_d = cmd_lvl_q;
            endcase
            if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_lvl_d = rx_lvl_q + 1'b1;
                2'b01:   rx_lvl_d = rx_lvl_q - 1'b1;
                default: rx_lvl_d = rx_lvl_q;
            endcase
        end
    end

    // Sticky and pending bits: a set in the same cycle as a W1C wins.
    always_comb begin
        cmd_ovf_d = (cmd_ovf_q & ~(wr_status & bus.i2c_writedata[21]))
                  | (wr_cmd & cmd_full & ~cmd_pop & ~flush);
        rx_ovf_d  = (rx_ovf_q & ~(wr_status & bus.i2c_writedata[22]))
                  | (rx_push_req & rx_full & ~rx_pop & ~flush);
        done_d    = (done_q & ~(wr_status & bus.i2c_writedata[23]))
                  | ((state_q == StDone) & cmd_empty);
        evt_set    = (~evt_mode_q & ~sync2_q) | (evt_mode_q & prev_q & ~sync2_q);
        evt_pend_d = evt_set
                   | (evt_pend_q & ~(wr_pend ? bus.i2c_writedata[N_EVT-1:0] : '0));
    end

    assign status_word = {8'h00, done_q, rx_ovf_q, cmd_ovf_q, core_idle, (state_q != StIdle),
                          rx_empty, cmd_empty, cmd_full,
                          {{(7 - RxAw){1'b0}}, rx_lvl_q}, {{(7 - CmdAw){1'b0}}, cmd_lvl_q}};

    always_comb begin
        readdata_d = readdata_q;
        if (rd) begin
            unique case (bus.i2c_address)
                3'd0:    readdata_d = rx_empty ? 32'h0 : rx_mem_q[rx_rptr_q];
                3'd1:    readdata_d = {27'h0, done_ie_q, rx_en_q, 1'b0, irq_en_q, ctrl_rst_q};
                3'd2:    readdata_d = status_word;
                3'd3:    readdata_d = {16'h0, dvsr_q};
                3'd4:    readdata_d = {{(32 - N_EVT){1'b0}}, evt_pend_q};
                3'd5:    readdata_d = {{(32 - N_EVT){1'b0}}, evt_mask_q};
                3'd6:    readdata_d = {{(32 - N_EVT){1'b0}}, evt_mode_q};
                default: readdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wptr_q] <= bus.i2c_writedata[25:0];
        if (rx_push)  rx_mem_q[rx_wptr_q]   <= core_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_lvl_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_lvl_q   <= '0;
            ctrl_rst_q <= 1'b0;
            irq_en_q   <= 1'b0;
            rx_en_q    <= 1'b0;
            done_ie_q  <= 1'b0;
            cmd_ovf_q  <= 1'b0;
            rx_ovf_q   <= 1'b0;
            done_q     <= 1'b0;
            dvsr_q     <= '0;
            evt_pend_q <= '0;
            evt_mask_q <= '0;
            evt_mode_q <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            prev_q     <= '1;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_wptr_q <= cmd_wptr_d;
            cmd_rptr_q <= cmd_rptr_d;
            cmd_lvl_q  <= cmd_lvl_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_lvl_q   <= rx_lvl_d;
            if (wr_ctrl) begin
                ctrl_rst_q <= bus.i2c_writedata[0];
                irq_en_q   <= bus.i2c_writedata[1];
                rx_en_q    <= bus.i2c_writedata[3];
                done_ie_q  <= bus.i2c_writedata[4];
            end
            cmd_ovf_q  <= cmd_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            done_q     <= done_d;
            if (wr_dvsr) dvsr_q     <= bus.i2c_writedata[15:0];
            if (wr_mask) evt_mask_q <= bus.i2c_writedata[N_EVT-1:0];
            if (wr_mode) evt_mode_q <= bus.i2c_writedata[N_EVT-1:0];
            evt_pend_q <= evt_pend_d;
            sync1_q    <= i2c_evt_n;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            readdata_q <= readdata_d;
        end
    end

    assign bus.i2c_readdata = readdata_q;
    assign i2c_reset = ctrl_rst_q;
    assign core_dvsr = dvsr_q;
    assign core_en   = (state_q == StIssue);
    assign core_data = {8'h00, cmd_head[23:0]};
    assign core_ben  = cmd_head[25:24];
    assign i2c_irq   = irq_en_q & ((|(evt_pend_q & evt_mask_q)) | (done_q & done_ie_q));
endmodule

// File: tb/tb_i2c_avalon_fifo.sv
// Scoreboard bench for i2c_avalon_fifo: expected engine commands and read data are queued by
// the stimulus and checked by monitors when the DUT pulses core_en or returns read data.
module tb_i2c_avalon_fifo;
    localparam int unsigned NEvt = 2;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_rd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_avalon_fifo_if bus();

    logic            irq, i2c_rst, core_en, core_idle;
    logic [31:0]     core_data;
    logic [31:0]     core_rdata;
    logic [1:0]      core_ben;
    logic [15:0]     core_dvsr;
    logic [NEvt-1:0] evt_n;

    i2c_avalon_fifo #(
        .CMD_DEPTH(8),
        .RX_DEPTH (8),
        .N_EVT    (NEvt)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .i2c_irq   (irq),
        .i2c_evt_n (evt_n),
        .i2c_reset (i2c_rst),
        .core_en   (core_en),
        .core_data (core_data),
        .core_ben  (core_ben),
        .core_dvsr (core_dvsr),
        .core_idle (core_idle),
        .core_rdata(core_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    exp_rd_t     exp_rd_q[$];
    logic [25:0] exp_cmd_q[$];
    logic [31:0] exp_res[9];

    function automatic logic [31:0] eng_result(input logic [1:0] ben, input logic [23:0] d);
        return {6'b101101, ben, d};
    endfunction

    // Engine model: busy for 4 cycles after each start pulse, result derived from the command.
    int   eng_cnt;
    logic hold_busy;
    always @(posedge clk) begin
        if (reset) begin
            eng_cnt    <= 0;
            core_rdata <= 32'h0;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
        end else if (core_en) begin
            eng_cnt    <= 4;
            core_rdata <= eng_result(core_ben, core_data[23:0]);
        end
    end
    assign core_idle = (eng_cnt == 0) && !hold_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= bus.i2c_chipselect & bus.i2c_read;

    always @(negedge clk) begin
        exp_rd_t r;
        if (rd_seen) begin
            if (exp_rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected read: got %08h, required no read", bus.i2c_readdata);
            end else begin
                r = exp_rd_q.pop_front();
                check(r.name, bus.i2c_readdata, r.val);
            end
        end
    end

    always @(negedge clk) begin
        logic [25:0] e;
        if (!reset && core_en) begin
            if (exp_cmd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected core_en: got ben=%0d data=%08h, required no pulse",
                         core_ben, core_data);
            end else begin
                e = exp_cmd_q.pop_front();
                check("core_data", core_data, {8'h00, e[23:0]});
                check("core_ben", {30'h0, core_ben}, {30'h0, e[25:24]});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.i2c_chipselect = 1'b1;
        bus.i2c_write      = 1'b1;
        bus.i2c_address    = a;
        bus.i2c_writedata  = d;
        tick(1);
        bus.i2c_chipselect = 1'b0;
        bus.i2c_write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        exp_rd_q.push_back('{val: exp, name: name});
        bus.i2c_chipselect = 1'b1;
        bus.i2c_read       = 1'b1;
        bus.i2c_address    = a;
        tick(1);
        bus.i2c_chipselect = 1'b0;
        bus.i2c_read       = 1'b0;
    endtask

    task automatic push_cmd(input logic [31:0] w, input bit issued);
        if (issued) exp_cmd_q.push_back(w[25:0]);
        bus_write(3'd0, w);
    endtask

    task automatic check_now(input string name, input logic act, input logic exp);
        @(negedge clk);
        check(name, {31'h0, act}, {31'h0, exp});
        @(posedge clk);
        #1;
    endtask

    // Line already driven low at the start of the current cycle; irq must rise in cycle 3.
    task automatic irq_latency(input string name);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check(name, {31'h0, irq}, {31'h0, (k == 3)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        bus.i2c_chipselect = 1'b0;
        bus.i2c_write      = 1'b0;
        bus.i2c_read       = 1'b0;
        bus.i2c_address    = 3'd0;
        bus.i2c_writedata  = 32'h0;
        evt_n     = '1;
        hold_busy = 1'b0;
        reset     = 1'b1;
        tick(3);
        reset = 1'b0;

        @(negedge clk);
        check("reset irq", {31'h0, irq}, 32'h0);
        check("reset i2c_reset", {31'h0, i2c_rst}, 32'h0);
        check("reset core_en", {31'h0, core_en}, 32'h0);
        check("reset readdata", bus.i2c_readdata, 32'h0);
        @(posedge clk);
        #1;
        bus_read(3'd1, 32'h0, "reset CTRL");
        bus_read(3'd2, 32'h0016_0000, "reset STATUS");
        bus_read(3'd3, 32'h0, "reset DVSR");
        bus_read(3'd4, 32'h0, "reset EVT_PEND");
        bus_read(3'd5, 32'h0, "reset EVT_MASK");
        bus_read(3'd6, 32'h0, "reset EVT_MODE");
        bus_read(3'd7, 32'h0, "reg7");

        bus_write(3'd3, 32'hABCD_1234);
        check("core_dvsr", {16'h0, core_dvsr}, 32'h0000_1234);
        bus_write(3'd1, 32'h0000_0001);
        check_now("i2c_reset out", i2c_rst, 1'b1);

        // Three back-to-back commands; upper write bits must not leak into the command.
        bus_write(3'd1, 32'h0000_0018);
        push_cmd(32'hFC00_00A5, 1'b1);
        push_cmd(32'h0100_003C, 1'b1);
        push_cmd(32'h0200_00FF, 1'b1);
        tick(60);
        bus_read(3'd2, 32'h0092_0300, "STATUS after 3 xfers");
        check_now("irq masked by irq_en", irq, 1'b0);
        bus_write(3'd1, 32'h0000_001A);
        check_now("irq from done", irq, 1'b1);
        bus_write(3'd2, 32'h0080_0000);
        check_now("irq after done W1C", irq, 1'b0);
        bus_read(3'd0, 32'hB400_00A5, "RX word 0");
        bus_read(3'd0, 32'hB500_003C, "RX word 1");
        bus_read(3'd0, 32'hB600_00FF, "RX word 2");
        bus_read(3'd0, 32'h0, "RX empty read");
        bus_read(3'd2, 32'h0016_0000, "STATUS drained");

        // Command FIFO overflow while the engine is held busy.
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) push_cmd(32'h0000_0010 + i, 1'b0);
        bus_read(3'd2, 32'h0025_0008, "STATUS cmd full+ovf");
        bus_write(3'd2, 32'h0020_0000);
        bus_read(3'd2, 32'h0005_0008, "STATUS cmd_ovf cleared");
        bus_write(3'd1, 32'h0000_001E);
        bus_read(3'd1, 32'h0000_001A, "CTRL flush self-clears");
        bus_read(3'd2, 32'h0006_0000, "STATUS after flush");
        hold_busy = 1'b0;

        // RX overflow: nine transfers with no CPU reads.
        for (int i = 0; i < 9; i++) begin
            w = 32'h0000_0020 + i;
            w[25:24] = 2'(i % 4);
            exp_res[i] = eng_result(w[25:24], w[23:0]);
            push_cmd(w, 1'b1);
        end
        tick(150);
        bus_read(3'd2, 32'h00D2_0800, "STATUS rx full+ovf");
        check_now("irq done after rx batch", irq, 1'b1);
        for (int i = 0; i < 8; i++) bus_read(3'd0, exp_res[i], $sformatf("RX ovf word %0d", i));
        bus_write(3'd2, 32'h00C0_0000);
        bus_read(3'd2, 32'h0016_0000, "STATUS rx_ovf cleared");

        // Events: line0 level mode, line1 falling-edge mode.
        bus_write(3'd5, 32'h0000_0003);
        bus_write(3'd6, 32'h0000_0002);
        evt_n[0] = 1'b0;
        irq_latency("irq level latency");
        tick(2);
        bus_read(3'd4, 32'h0000_0001, "pend0 set");
        bus_write(3'd4, 32'h0000_0001);
        bus_read(3'd4, 32'h0000_0001, "pend0 re-set while low");
        evt_n[0] = 1'b1;
        tick(4);
        bus_write(3'd4, 32'h0000_0001);
        bus_read(3'd4, 32'h0, "pend0 cleared after release");
        check_now("irq idle", irq, 1'b0);
        evt_n[1] = 1'b0;
        irq_latency("irq edge latency");
        bus_write(3'd4, 32'h0000_0002);
        evt_n[1] = 1'b1;
        bus_read(3'd4, 32'h0, "pend1 set once");
        check_now("irq after edge W1C", irq, 1'b0);
        bus_read(3'd6, 32'h0000_0002, "EVT_MODE readback");

        // Flush while the first of four commands is in flight.
        push_cmd(32'h0000_0040, 1'b1);
        push_cmd(32'h0000_0041, 1'b0);
        push_cmd(32'h0000_0042, 1'b0);
        push_cmd(32'h0000_0043, 1'b0);
        bus_write(3'd1, 32'h0000_001E);
        bus_read(3'd2, 32'h000E_0000, "STATUS flush in WAIT_DONE");
        tick(30);
        bus_read(3'd2, 32'h0092_0100, "STATUS in-flight landed");
        bus_read(3'd0, 32'hB400_0040, "RX in-flight word");
        bus_write(3'd2, 32'h0080_0000);
        bus_read(3'd2, 32'h0016_0000, "STATUS final");

        tick(5);
        check("pending core_en pulses", exp_cmd_q.size(), 32'd0);
        check("pending reads", exp_rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_avalon_fifo.md
# i2c_avalon_fifo

Avalon-MM slave front-end for the I2C byte engine, replacing the single-shot register wrapper. Writes are queued into a parametrised command FIFO and dispatched to the engine back-to-back without CPU involvement. Optionally, engine read data is captured into an RX FIFO. Touch and peripheral event lines are generalised to `N_EVT` maskable channels, each in level or edge mode, combined with a transfer-done source into one interrupt.

## Interface
- `CMD_DEPTH`, 8, command FIFO entries; power of two, 2..64
- `RX_DEPTH`, 8, RX FIFO entries; power of two, 2..64
- `N_EVT`, 1, event input channels, 1..16
- `clk` in 1: single clock for the whole block
- `reset` in 1: synchronous, active-high
- `i2c_chipselect`, `i2c_write`, `i2c_read` in 1: Avalon strobes
- `i2c_address` in 3: word address
- `i2c_writedata` in 32
- `i2c_readdata` out 32: registered read data
- `i2c_irq` out 1: level interrupt
- `i2c_evt_n` in `N_EVT`: asynchronous event lines, active-low
- `i2c_reset` out 1: peripheral reset, driven from CTRL[0]
- `core_en` out 1: one-cycle start pulse to the engine
- `core_data` out 32
- `core_ben` out 2
- `core_dvsr` out 16: engine clock divisor
- `core_idle` in 1: engine idle
- `core_rdata` in 32: engine result

## Operation
Register map (wr = `chipselect & write`, rd = `chipselect & read`):
- 0 CMD/RX
  - Write pushes `{writedata[25:24]` → ben, `writedata[23:0]` → data, zero-extended to 32} into the command FIFO.
  - Read pops the RX FIFO head. If the RX FIFO is empty: returns 0, no pop.
- 1 CTRL rw
  - [0] `i2c_reset`, [1] irq_en, [3] rx_en, [4] done_ie.
  - [2] flush: write-only, self-clearing; empties both FIFOs in the same cycle.
- 2 STATUS r
  - [7:0] cmd level, [15:8] rx level.
  - [16] cmd_full, [17] cmd_empty, [18] rx_empty, [19] busy (FSM≠IDLE), [20] core_idle.
  - [21] cmd_ovf, [22] rx_ovf, [23] done: sticky, write-1-to-clear at the same bits.
- 3 DVSR rw [15:0] → `core_dvsr`.
- 4 EVT_PEND r/W1C [N_EVT-1:0].
- 5 EVT_MASK rw.
- 6 EVT_MODE rw: bit=0 level (pend set every cycle the line is low), bit=1 falling edge only.
- 7 reads 0, writes ignored.

Dispatcher FSM:
- IDLE: if cmd FIFO non-empty and `core_idle`=1 → ISSUE.
- ISSUE: one cycle. `core_en`=1 with `core_data`/`core_ben` = FIFO head. Pop the command FIFO. → WAIT_START.
- WAIT_START: when `core_idle`=0 → WAIT_DONE.
- WAIT_DONE: when `core_idle`=1 → DONE.
- DONE: one cycle.
  - If rx_en: push `core_rdata` into RX FIFO. If RX is full, drop the word and set rx_ovf.
  - If the command FIFO is empty, set done.
  - → IDLE.

Events:
- 2-FF synchroniser per line; reset value 1 (inactive).
- Edge detect compares synchroniser output against its previous value.
- `i2c_irq = irq_en & (|(EVT_PEND & EVT_MASK) | (done & done_ie))`.

## Timing
- Reset: all registers 0, FIFOs empty, FSM IDLE, sync flops 1. Outputs `i2c_irq`, `i2c_reset`, `core_en` = 0; `i2c_readdata` = 0.
- Read latency 1 cycle. Data is captured on the edge after the rd cycle. A pop happens only if rd, addr=0 and not empty.
- Write takes effect on the clock edge of the wr cycle. A status read on the next cycle sees the new level.
- Command push with FIFO full: dropped, cmd_ovf set. Exception: push in the same cycle as an ISSUE pop is accepted, and the level stays at `CMD_DEPTH`.
- RX push and CPU pop in the same cycle: both occur; a full RX FIFO does not overflow.
- Set beats W1C: a pend/sticky bit set and cleared in the same cycle ends set.
- Flush does not abort an in-flight transfer. Its DONE push into RX proceeds normally after the flush. Flush and push in the same cycle: flush wins, push discarded.
- Minimum back-to-back spacing between `core_en` pulses: ISSUE + WAIT_START + WAIT_DONE + DONE + IDLE = 5 cycles, plus engine busy time.
- Level-mode event: `i2c_irq` rises 3 cycles after the line falls (2 sync + pend register). Edge mode: same latency, one set per falling edge.
- Pointers wrap modulo depth. Levels are `log2(DEPTH)+1` bits, zero-extended to 8.

## Test plan
- Reset, then read regs 1–6 → all 0, except STATUS[17], [18] and [20] (cmd_empty, rx_empty, and core_idle as driven by the engine model).
- Engine model with 4-cycle busy; rx_en=1; push 3 commands 0x0000A5, 0x0100_3C, 0x0200_FF:
  - three `core_en` pulses, in order, with ben 0, 1, 2;
  - RX level 3; done=1;
  - three addr0 reads return the model results in order.
- Push 9 commands with `CMD_DEPTH`=8 while `core_idle`=0 held → level 8, cmd_ovf=1. W1C bit 21 → cmd_ovf=0.
- rx_en=1, `RX_DEPTH`=8, run 9 transfers without reads → rx level 8, rx_ovf=1, first 8 results preserved.
- N_EVT=2, mask=0b11, irq_en=1, mode=0b10:
  - hold line0 low → pend[0] re-sets after W1C while low;
  - pulse line1 low for 5 cycles → pend[1] set once, `i2c_irq`=1 three cycles after the fall.
- Flush during WAIT_DONE with 4 queued commands → cmd level 0 next cycle, in-flight result still lands in RX, no further `core_en`.
